// File: rtl/adpll_cfg_writer.sv
// adpll_cfg_writer: host-side programming sequencer for the ADPLL parameter-load pins.
// Turns valid/ready write requests into pgm/clr pulses with fixed setup, pulse width
// and hold, and runs an init sequence (clear, then load NUM_PARAMS defaults).
// Optional feature macro: ADPLL_CFG_SHADOW_EN (per-index shadow of programmed values;
// host writes that would not change the value are skipped).
module adpll_cfg_writer #(
  parameter int          SETUP_CYC  = 2,
  parameter int          PULSE_CYC  = 2,
  parameter int          HOLD_CYC   = 2,
  parameter int          NUM_PARAMS = 8,
  parameter logic [39:0] DEFAULTS   = 40'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_init,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_clr,
  input  logic [2:0] req_sel,
  input  logic [4:0] req_value,
  output logic       busy,
  output logic       init_done,
  output logic       pgm,
  output logic       clr,
  output logic [2:0] param_sel,
  output logic [4:0] pgm_value,
  input  logic [2:0] shadow_rd_sel,
  output logic [4:0] shadow_rd_data
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    PULSE     = 3'd2,
    HOLD      = 3'd3,
    CLR_PULSE = 3'd4,
    CLR_HOLD  = 3'd5
  } state_t;

  // One shared phase counter, wide enough for the longest phase.
  localparam int CNT_MAX = (SETUP_CYC > PULSE_CYC) ?
                           ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                           ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [2:0]       LAST_IDX   = 3'(NUM_PARAMS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             init_mode_q, init_mode_d;
  logic             init_done_q, init_done_d;
  logic             pgm_q, pgm_d;
  logic             clr_q, clr_d;
  logic             busy_q, busy_d;
  logic [2:0]       param_sel_q, param_sel_d;
  logic [4:0]       pgm_value_q, pgm_value_d;
  logic             accept_s;
  logic             skip_s;
  logic             shadow_wr_s;
  logic             shadow_clr_s;

  // Default value of parameter idx, sliced from the packed DEFAULTS vector.
  function automatic logic [4:0] default_val(input logic [2:0] idx);
    case (idx)
      3'd0:    return DEFAULTS[4:0];
      3'd1:    return DEFAULTS[9:5];
      3'd2:    return DEFAULTS[14:10];
      3'd3:    return DEFAULTS[19:15];
      3'd4:    return DEFAULTS[24:20];
      3'd5:    return DEFAULTS[29:25];
      3'd6:    return DEFAULTS[34:30];
      3'd7:    return DEFAULTS[39:35];
      default: return 5'd0;
    endcase
  endfunction

  assign req_ready = (state_q == IDLE) & ~start_init & ~rst;
  assign accept_s  = req_valid & req_ready;

  // Next-state, phase counter, init bookkeeping and bus values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    init_mode_d  = init_mode_q;
    init_done_d  = init_done_q;
    param_sel_d  = param_sel_q;
    pgm_value_d  = pgm_value_q;
    shadow_wr_s  = 1'b0;
    shadow_clr_s = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (start_init) begin
          init_done_d = 1'b0;
          init_mode_d = 1'b1;
          idx_d       = 3'd0;
          param_sel_d = 3'd0;
          pgm_value_d = 5'd0;
          state_d     = CLR_PULSE;
        end else if (accept_s && req_clr) begin
          init_mode_d = 1'b0;
          param_sel_d = 3'd0;
          pgm_value_d = 5'd0;
          state_d     = CLR_PULSE;
        end else if (accept_s && !skip_s) begin
          init_mode_d = 1'b0;
          param_sel_d = req_sel;
          pgm_value_d = req_value;
          state_d     = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PULSE: begin
        shadow_wr_s = (cnt_q == {CNT_W{1'b0}});
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q != HOLD_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (init_mode_q && (idx_q != LAST_IDX)) begin
          cnt_d       = {CNT_W{1'b0}};
          idx_d       = idx_q + 3'd1;
          param_sel_d = idx_q + 3'd1;
          pgm_value_d = default_val(idx_q + 3'd1);
          state_d     = SETUP;
        end else if (init_mode_q) begin
          cnt_d       = {CNT_W{1'b0}};
          init_mode_d = 1'b0;
          init_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = IDLE;
        end
      end
      CLR_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d        = {CNT_W{1'b0}};
          shadow_clr_s = 1'b1;
          state_d      = CLR_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CLR_HOLD: begin
        if (cnt_q != HOLD_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (init_mode_q) begin
          cnt_d       = {CNT_W{1'b0}};
          param_sel_d = idx_q;
          pgm_value_d = default_val(idx_q);
          state_d     = SETUP;
        end else begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = IDLE;
      end
    endcase
  end

  // Pin values are decoded from the next state so they register alongside it.
  always_comb begin
    pgm_d  = (state_d == PULSE);
    clr_d  = (state_d == CLR_PULSE);
    busy_d = (state_d != IDLE);
  end

  // State and registered pin outputs; reset drops pgm/clr immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      idx_q       <= 3'd0;
      init_mode_q <= 1'b0;
      init_done_q <= 1'b0;
      pgm_q       <= 1'b0;
      clr_q       <= 1'b0;
      busy_q      <= 1'b0;
      param_sel_q <= 3'd0;
      pgm_value_q <= 5'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      init_mode_q <= init_mode_d;
      init_done_q <= init_done_d;
      pgm_q       <= pgm_d;
      clr_q       <= clr_d;
      busy_q      <= busy_d;
      param_sel_q <= param_sel_d;
      pgm_value_q <= pgm_value_d;
    end
  end

  assign pgm       = pgm_q;
  assign clr       = clr_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign param_sel = param_sel_q;
  assign pgm_value = pgm_value_q;

`ifdef ADPLL_CFG_SHADOW_EN
  logic [4:0] shadow_q [8];
  logic [4:0] shadow_d [8];

  // Shadow next value: wiped when a clear pulse ends, captured on the first pulse cycle.
  always_comb begin
    shadow_d = shadow_q;
    if (shadow_clr_s) begin
      for (int i = 0; i < 8; i++) shadow_d[i] = 5'd0;
    end else if (shadow_wr_s) begin
      shadow_d[param_sel_q] = pgm_value_q;
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Shadow storage of the last programmed value per index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) shadow_q[i] <= 5'd0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign shadow_rd_data = shadow_q[shadow_rd_sel];
  assign skip_s         = ~req_clr & (shadow_q[req_sel] == req_value);
`else
  logic unused_s;
  assign unused_s       = ^{shadow_wr_s, shadow_clr_s, shadow_rd_sel};
  assign shadow_rd_data = 5'd0;
  assign skip_s         = 1'b0;
`endif

endmodule

// File: tb/tb_adpll_cfg_writer.sv
// Self-checking bench for adpll_cfg_writer: a transaction-level trace model predicts
// every output each cycle; directed scenarios add hand-computed literal expectations.
module tb_adpll_cfg_writer;

  localparam int PH = 2;  // setup, pulse and hold length used by this bench
  localparam logic [39:0] DEF = {5'h1F, 5'h07, 5'h06, 5'h05, 5'h04, 5'h03, 5'h02, 5'h11};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_init = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_clr = 1'b0;
  logic [2:0] req_sel = 3'd0;
  logic [4:0] req_value = 5'd0;
  logic [2:0] shadow_rd_sel = 3'd0;
  logic       req_ready, busy, init_done, pgm, clr;
  logic [2:0] param_sel;
  logic [4:0] pgm_value, shadow_rd_data;

  int checks = 0;
  int errors = 0;

  adpll_cfg_writer #(.SETUP_CYC(PH), .PULSE_CYC(PH), .HOLD_CYC(PH), .NUM_PARAMS(8),
                     .DEFAULTS(DEF)) dut (
    .clk(clk), .rst(rst), .start_init(start_init), .req_valid(req_valid),
    .req_ready(req_ready), .req_clr(req_clr), .req_sel(req_sel), .req_value(req_value),
    .busy(busy), .init_done(init_done), .pgm(pgm), .clr(clr), .param_sel(param_sel),
    .pgm_value(pgm_value), .shadow_rd_sel(shadow_rd_sel), .shadow_rd_data(shadow_rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- trace model: one entry per expected output cycle ----------------
  typedef struct packed {
    logic       pgm;
    logic       clr;
    logic       busy;
    logic [2:0] sel;
    logic [4:0] val;
    logic       sh_wr;   // shadow captures sel/val when this cycle ends
    logic       sh_clr;  // shadow is wiped when this cycle ends
    logic       done;    // init_done rises when this cycle ends
  } ent_t;

  ent_t       q[$];
  ent_t       cur = '0;
  logic       m_done = 1'b0;
  logic [4:0] m_sh [8];

  function automatic logic [4:0] defv(input int i);
    logic [39:0] d = DEF;
    return d[5*i +: 5];
  endfunction

  task automatic push_write(input logic [2:0] s, input logic [4:0] v, input logic last);
    ent_t e;
    for (int k = 0; k < 3*PH; k++) begin
      e = '0;
      e.busy  = 1'b1;
      e.sel   = s;
      e.val   = v;
      e.pgm   = (k >= PH) && (k < 2*PH);
      e.sh_wr = (k == PH);
      e.done  = last && (k == 3*PH-1);
      q.push_back(e);
    end
  endtask

  task automatic push_clear();
    ent_t e;
    for (int k = 0; k < 2*PH; k++) begin
      e = '0;
      e.busy   = 1'b1;
      e.clr    = (k < PH);
      e.sh_clr = (k == PH-1);
      q.push_back(e);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_sh[i] = 5'd0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        cur = '0;
        m_done = 1'b0;
        for (int i = 0; i < 8; i++) m_sh[i] = 5'd0;
      end else begin
        if (cur.sh_wr) m_sh[cur.sel] = cur.val;
        if (cur.sh_clr) for (int i = 0; i < 8; i++) m_sh[i] = 5'd0;
        if (cur.done) m_done = 1'b1;
        if (!cur.busy) begin
          if (start_init) begin
            m_done = 1'b0;
            push_clear();
            for (int i = 0; i < 8; i++) push_write(3'(i), defv(i), i == 7);
          end else if (req_valid) begin
            if (req_clr) push_clear();
`ifdef ADPLL_CFG_SHADOW_EN
            else if (m_sh[req_sel] == req_value) begin end
`endif
            else push_write(req_sel, req_value, 1'b0);
          end
        end
        if (q.size() > 0) begin
          cur = q.pop_front();
        end else begin
          cur.pgm = 1'b0; cur.clr = 1'b0; cur.busy = 1'b0;
          cur.sh_wr = 1'b0; cur.sh_clr = 1'b0; cur.done = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model, away from the active edge.
  initial begin
    logic [17:0] exp_v, act_v;
    logic [4:0]  sh_exp;
    forever begin
      @(negedge clk);
`ifdef ADPLL_CFG_SHADOW_EN
      sh_exp = m_sh[shadow_rd_sel];
`else
      sh_exp = 5'd0;
`endif
      exp_v = {~rst & ~cur.busy & ~start_init, cur.pgm, cur.clr, cur.busy,
               cur.sel, cur.val, m_done, sh_exp};
      act_v = {req_ready, pgm, clr, busy, param_sel, pgm_value, init_done, shadow_rd_data};
      check("model_cycle", 32'(act_v), 32'(exp_v));
    end
  end

  // Event monitor: logs pgm pulses and counts clr/busy cycles for the directed checks.
  int         clr_total = 0;
  int         busy_total = 0;
  logic [2:0] pulse_sel[$];
  logic [4:0] pulse_val[$];
  initial begin
    logic pgm_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (pgm && !pgm_prev) begin
        pulse_sel.push_back(param_sel);
        pulse_val.push_back(pgm_value);
      end
      if (clr) clr_total++;
      if (busy) busy_total++;
      pgm_prev = pgm;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    check(nm, 32'(busy), 32'd0);
  endtask

  task automatic issue(input logic c, input logic [2:0] s, input logic [4:0] v);
    req_valid = 1'b1; req_clr = c; req_sel = s; req_value = v;
    tick();
    req_valid = 1'b0; req_clr = 1'b0;
  endtask

  initial begin
    int p0, c0, b0, n, bad;
    logic [7:1] pgm_pat;

    // Reset state
    repeat (3) tick();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_outs", 32'({pgm, clr, busy, init_done, param_sel, pgm_value}), 32'd0);
    rst = 1'b0;
    tick();

    // Init sequence
    start_init = 1'b1;
    #1 check("init_ready_low", 32'(req_ready), 32'd0);
    p0 = pulse_val.size(); c0 = clr_total;
    tick();
    start_init = 1'b0;
    n = 0;
    while (!init_done && n < 200) begin tick(); n++; end
    check("init_done", 32'(init_done), 32'd1);
    check("init_pulses", 32'(pulse_val.size() - p0), 32'd8);
    check("init_clr_width", 32'(clr_total - c0), 32'd2);
    check("init_first", 32'({pulse_sel[p0], pulse_val[p0]}), {24'd0, 3'd0, 5'h11});
    check("init_last", 32'({pulse_sel[p0+7], pulse_val[p0+7]}), {24'd0, 3'd7, 5'h1F});

    // Single write timing: sel=3 val=0x0A accepted at edge T
    req_valid = 1'b1; req_sel = 3'd3; req_value = 5'h0A;
    #1 check("wr_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    pgm_pat = 7'b0001100;
    for (int k = 1; k <= 7; k++) begin
      check("wr_bus", 32'({param_sel, pgm_value}), {24'd0, 3'd3, 5'h0A});
      check("wr_pgm", 32'(pgm), 32'(pgm_pat[k]));
      check("wr_ready_back", 32'(req_ready), (k == 7) ? 32'd1 : 32'd0);
      if (k < 7) tick();
    end

    // start_init and req_valid together: init wins, the write never happens
    req_valid = 1'b1; req_sel = 3'd3; req_value = 5'h15; start_init = 1'b1;
    #1 check("coll_ready", 32'(req_ready), 32'd0);
    p0 = pulse_val.size();
    tick();
    req_valid = 1'b0; start_init = 1'b0;
    check("coll_done_clr", 32'(init_done), 32'd0);
    n = 0;
    while (!init_done && n < 200) begin tick(); n++; end
    check("coll_done", 32'(init_done), 32'd1);
    check("coll_pulses", 32'(pulse_val.size() - p0), 32'd8);
    bad = 0;
    for (int i = p0; i < pulse_val.size(); i++) if (pulse_val[i] == 5'h15) bad++;
    check("coll_no_write", 32'(bad), 32'd0);

    // Reset while pgm is high
    issue(1'b0, 3'd2, 5'h09);
    n = 0;
    while (!pgm && n < 10) begin tick(); n++; end
    check("rp_saw_pgm", 32'(pgm), 32'd1);
    rst = 1'b1;
    #1 check("rp_outs_zero", 32'({pgm, clr, busy}), 32'd0);
    tick(); tick();
    rst = 1'b0;
    #1 check("rp_ready", 32'(req_ready), 32'd1);
    check("rp_init_done", 32'(init_done), 32'd0);

    // Host clear after a write left a non-zero bus
    tick();
    issue(1'b0, 3'd6, 5'h1C);
    wait_idle("hc_prewrite_idle", 20);
    check("hc_prewrite_bus", 32'({param_sel, pgm_value}), {24'd0, 3'd6, 5'h1C});
    p0 = pulse_val.size(); c0 = clr_total; b0 = busy_total;
    issue(1'b1, 3'd5, 5'h1F);
    check("hc_bus_zero", 32'({clr, param_sel, pgm_value}), {23'd0, 1'b1, 3'd0, 5'd0});
    wait_idle("hc_idle", 20);
    check("hc_clr_width", 32'(clr_total - c0), 32'd2);
    check("hc_busy_cycles", 32'(busy_total - b0), 32'd4);
    check("hc_no_pgm", 32'(pulse_val.size() - p0), 32'd0);
    check("hc_ready", 32'(req_ready), 32'd1);

    // Repeated write of idx5=0x07
    shadow_rd_sel = 3'd5;
    issue(1'b0, 3'd5, 5'h07);
    wait_idle("dup_first_idle", 20);
    p0 = pulse_val.size();
    issue(1'b0, 3'd5, 5'h07);
`ifdef ADPLL_CFG_SHADOW_EN
    check("dup_busy", 32'(busy), 32'd0);
    check("dup_ready", 32'(req_ready), 32'd1);
    repeat (6) tick();
    check("dup_no_pgm", 32'(pulse_val.size() - p0), 32'd0);
    check("sh_read", 32'(shadow_rd_data), 32'h07);
`else
    check("dup_busy", 32'(busy), 32'd1);
    wait_idle("dup_second_idle", 20);
    check("dup_pulsed", 32'(pulse_val.size() - p0), 32'd1);
    check("sh_read", 32'(shadow_rd_data), 32'd0);
`endif
    issue(1'b1, 3'd0, 5'd0);
    wait_idle("sh_clr_idle", 20);
    check("sh_after_clr", 32'(shadow_rd_data), 32'd0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adpll_cfg_writer.md
Name: adpll_cfg_writer

Overview:
Host-side programming sequencer that drives the ADPLL parameter-load pins (clr, pgm, param_sel[2:0], pgm_value[4:0]). It is the writer end of the interface the ADPLL top samples. It turns single-cycle valid/ready write requests into pgm/clr pulses with guaranteed setup, pulse width and hold. It also runs an init sequence: clear, then load NUM_PARAMS default values. It sits beside the ADPLL wrapper and is clocked by the same 50 MHz sampling clock.

Parameters:
SETUP_CYC, 2, cycles param_sel/pgm_value are stable before pgm rises (>=1)
PULSE_CYC, 2, width of a pgm or clr pulse in cycles (>=1)
HOLD_CYC, 2, cycles bus is held after pgm/clr falls (>=1)
NUM_PARAMS, 8, defaults written during init (1..8), indices 0..NUM_PARAMS-1
DEFAULTS, 40'h0, default value of param i at bits [5i+4:5i]

Ports:
clk  in  1  sampling clock
rst  in  1  asynchronous, active-high reset
start_init  in  1  one-cycle strobe: run clear + default-load sequence
req_valid  in  1  write request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_clr  in  1  with request: issue clr pulse instead of a parameter write
req_sel  in  3  parameter index
req_value  in  5  parameter value
busy  out  1  sequence in progress (state != IDLE)
init_done  out  1  sticky, set when init sequence completes
pgm  out  1  to ADPLL pgm
clr  out  1  to ADPLL clr
param_sel  out  3  to ADPLL param_sel
pgm_value  out  5  to ADPLL pgm_value
shadow_rd_sel  in  3  shadow readback index
shadow_rd_data  out  5  shadow readback data

Behaviour:
- Reset (async, rst=1): all outputs 0: pgm, clr, param_sel, pgm_value, busy, init_done, shadow_rd_data. req_ready=0 while rst=1. State=IDLE, init index=0.
- pgm, clr, param_sel, pgm_value and busy are registered. req_ready = (state==IDLE) & ~start_init & ~rst.
- States: IDLE, SETUP, PULSE, HOLD, CLR_PULSE, CLR_HOLD.
- IDLE + start_init: init_done<=0, index<=0, go to CLR_PULSE. start_init wins over a simultaneous req_valid; that request is not accepted.
- IDLE + accepted request, req_clr=1: go to CLR_PULSE. req_sel and req_value are ignored.
- IDLE + accepted request, req_clr=0: latch req_sel and req_value onto param_sel and pgm_value, then go to SETUP.
- Write timing for an accept at edge T: bus valid from T+1. SETUP covers SETUP_CYC cycles. pgm=1 for the next PULSE_CYC cycles (PULSE). HOLD covers HOLD_CYC cycles with pgm=0 and the bus still held. Then IDLE.
- With defaults: pgm high in cycles T+3..T+4, req_ready high again at T+7. Next accept is possible at T+7.
- Clear timing: CLR_PULSE drives clr=1 for PULSE_CYC cycles, param_sel=0, pgm_value=0. CLR_HOLD lasts HOLD_CYC cycles with clr=0.
- After CLR_HOLD in an init sequence: load param_sel=index and pgm_value=DEFAULTS[5*index+:5], then go to SETUP. After each HOLD, index++ until index==NUM_PARAMS-1. After the last HOLD, set init_done=1 and return to IDLE.
- After CLR_HOLD for a host clear: return to IDLE. init_done is unchanged.
- pgm and clr are never high in the same cycle. param_sel and pgm_value never change while pgm=1.
- start_init or req_valid while busy: ignored, no queuing. The host must retry.
- A reset mid-sequence aborts immediately, with pgm and clr forced to 0 asynchronously.
- Counters are sized from max(SETUP_CYC, PULSE_CYC, HOLD_CYC) and compared against value-1. There is no wrap.

Optional Feature:
ADPLL_CFG_SHADOW_EN.
- Defined:
  - An 8x5 shadow register array tracks the last programmed value per index.
  - Shadow is zeroed by reset and at the end of every CLR_PULSE. It is updated on the first PULSE cycle of a write.
  - shadow_rd_data = shadow[shadow_rd_sel], combinational.
  - A host write (req_clr=0) whose req_value equals shadow[req_sel] is skipped: it is accepted, busy is 0, no pgm pulse is issued, and req_ready stays 1 the next cycle.
  - Init writes are never skipped.
- Undefined: no shadow storage, shadow_rd_data tied to 0, every write is pulsed.

Test Plan:
- Reset, then start_init with NUM_PARAMS=8 and DEFAULTS[4:0]=5'h11, DEFAULTS[39:35]=5'h1F. Required:
  - one clr pulse 2 cycles wide,
  - then 8 pgm pulses with param_sel 0..7 and pgm_value 0x11 first, 0x1F last,
  - init_done=1 after the final HOLD.
- Idle write req_sel=3, req_value=5'h0A accepted at edge T. Required: param_sel=3 and pgm_value=0x0A from T+1, pgm=1 only in T+3..T+4, req_ready=1 at T+7.
- start_init and req_valid in the same cycle: req_ready=0 that cycle, the init sequence runs, no write of req_sel occurs.
- Assert rst during PULSE. Required: pgm, clr and busy go to 0 at once. After release, IDLE with req_ready=1 and init_done=0.
- req_clr=1 request: clr high 2 cycles, param_sel and pgm_value 0, no pgm pulse, req_ready back after 4 cycles of busy.
- With ADPLL_CFG_SHADOW_EN: write idx5=0x07, then idx5=0x07 again. Required: second write has no pgm pulse and busy stays 0. shadow_rd_sel=5 reads 0x07, and reads 0 after a req_clr.
